// File: rtl/resource_pkg.sv
// rtl/resource_pkg.sv - kind encoding, FSM state type and pool limits for resource_dispenser
package resource_pkg;

    localparam logic [1:0] KIND_ENERGY   = 2'd0;
    localparam logic [1:0] KIND_TRACER   = 2'd1;
    localparam logic [1:0] KIND_FLUID    = 2'd2;
    localparam logic [1:0] KIND_RESERVED = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam int ENERGY_W = 8;
    localparam int TRACER_W = 6;
    localparam int FLUID_W  = 4;

    localparam logic [ENERGY_W-1:0] ENERGY_MAX = 8'd255;
    localparam logic [TRACER_W-1:0] TRACER_MAX = 6'd63;
    localparam logic [FLUID_W-1:0]  FLUID_MAX  = 4'd15;

endpackage

// File: rtl/resource_subtractor.sv
// rtl/resource_subtractor.sv - per-pool sufficiency test and difference for a W-bit pool level
module resource_subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] level,
    input  logic [7:0]   amount,
    output logic         ok,
    output logic [W-1:0] result
);

    logic [7:0] level_ext;

    // A level never exceeds its pool maximum, so amount <= level also rejects
    // any amount larger than the pool can ever hold.
    assign level_ext = 8'(level);
    assign ok        = (amount <= level_ext);
    assign result    = level - amount[W-1:0];

endmodule

// File: rtl/resource_dispenser.sv
// rtl/resource_dispenser.sv - three-pool withdrawal FSM; trickle recharge under RESOURCE_DISPENSER_RECHARGE_EN
module resource_dispenser
    import resource_pkg::*;
#(
    parameter int RECHARGE_PERIOD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_kind,
    input  logic [7:0]          req_amount,
    input  logic                refill,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_grant,
    output logic [1:0]          rsp_kind,
    output logic [7:0]          rsp_remaining,
    output logic [ENERGY_W-1:0] energy_lvl,
    output logic [TRACER_W-1:0] tracer_lvl,
    output logic [FLUID_W-1:0]  fluid_lvl
);

    state_t        state;
    logic [1:0]    kind_q;
    logic [7:0]    amount_q;
    logic          grant_q;
    logic          e_ok, t_ok, f_ok;
    logic [ENERGY_W-1:0] e_res;
    logic [TRACER_W-1:0] t_res;
    logic [FLUID_W-1:0]  f_res;
    logic          sel_ok;
    logic [7:0]    sel_res;
    logic [7:0]    sel_lvl;
    logic          idle_free;
    logic          apply_tick;

    resource_subtractor #(.W(ENERGY_W)) u_energy (.level(energy_lvl), .amount(amount_q), .ok(e_ok), .result(e_res));
    resource_subtractor #(.W(TRACER_W)) u_tracer (.level(tracer_lvl), .amount(amount_q), .ok(t_ok), .result(t_res));
    resource_subtractor #(.W(FLUID_W))  u_fluid  (.level(fluid_lvl),  .amount(amount_q), .ok(f_ok), .result(f_res));

    always_comb begin
        sel_ok  = 1'b0;
        sel_res = 8'd0;
        sel_lvl = 8'd0;
        case (kind_q)
            KIND_ENERGY: begin sel_ok = e_ok; sel_res = 8'(e_res); sel_lvl = 8'(energy_lvl); end
            KIND_TRACER: begin sel_ok = t_ok; sel_res = 8'(t_res); sel_lvl = 8'(tracer_lvl); end
            KIND_FLUID:  begin sel_ok = f_ok; sel_res = 8'(f_res); sel_lvl = 8'(fluid_lvl);  end
            default:     begin sel_ok = 1'b0; sel_res = 8'd0;      sel_lvl = 8'd0;            end
        endcase
    end

    // Gated by reset so the port reads 0 for the whole time reset is held.
    assign req_ready = reset && (state == ST_IDLE) && !refill;
    assign rsp_valid = (state == ST_RESP);
    assign idle_free = (state == ST_IDLE) && !refill;

`ifdef RESOURCE_DISPENSER_RECHARGE_EN
    logic [7:0] rc_cnt;
    logic       rc_tick;
    logic       rc_pending;

    assign rc_tick    = (rc_cnt == 8'(RECHARGE_PERIOD - 1));
    assign apply_tick = idle_free && (rc_tick || rc_pending);

    // Ticks landing outside a free IDLE cycle collapse into one pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rc_cnt     <= 8'd0;
            rc_pending <= 1'b0;
        end else begin
            rc_cnt <= rc_tick ? 8'd0 : rc_cnt + 8'd1;
            if ((state == ST_IDLE) && refill)
                rc_pending <= 1'b0;
            else if (idle_free)
                rc_pending <= 1'b0;
            else if (rc_tick)
                rc_pending <= 1'b1;
        end
    end
`else
    assign apply_tick = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            kind_q        <= 2'd0;
            amount_q      <= 8'd0;
            grant_q       <= 1'b0;
            rsp_grant     <= 1'b0;
            rsp_kind      <= 2'd0;
            rsp_remaining <= 8'd0;
            energy_lvl    <= ENERGY_MAX;
            tracer_lvl    <= TRACER_MAX;
            fluid_lvl     <= FLUID_MAX;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refill) begin
                        energy_lvl <= ENERGY_MAX;
                        tracer_lvl <= TRACER_MAX;
                        fluid_lvl  <= FLUID_MAX;
                    end else begin
                        if (apply_tick) begin
                            energy_lvl <= (energy_lvl == ENERGY_MAX) ? energy_lvl : energy_lvl + 1'b1;
                            tracer_lvl <= (tracer_lvl == TRACER_MAX) ? tracer_lvl : tracer_lvl + 1'b1;
                            fluid_lvl  <= (fluid_lvl  == FLUID_MAX)  ? fluid_lvl  : fluid_lvl  + 1'b1;
                        end
                        if (req_valid) begin
                            kind_q   <= req_kind;
                            amount_q <= req_amount;
                            state    <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    grant_q <= (kind_q != KIND_RESERVED) && sel_ok;
                    state   <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (grant_q) begin
                        case (kind_q)
                            KIND_ENERGY: energy_lvl <= e_res;
                            KIND_TRACER: tracer_lvl <= t_res;
                            KIND_FLUID:  fluid_lvl  <= f_res;
                            default:     ;
                        endcase
                    end
                    rsp_grant     <= grant_q;
                    rsp_kind      <= kind_q;
                    rsp_remaining <= grant_q ? sel_res : sel_lvl;
                    state         <= ST_RESP;
                end
                default: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resource_dispenser.sv
// tb/tb_resource_dispenser.sv - randomized self-checking bench for resource_dispenser
module tb_resource_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       refill = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [1:0] req_kind = 2'd0;
    logic [7:0] req_amount = 8'd0;
    logic       req_ready, rsp_valid, rsp_grant;
    logic [1:0] rsp_kind;
    logic [7:0] rsp_remaining;
    logic [7:0] energy_lvl;
    logic [5:0] tracer_lvl;
    logic [3:0] fluid_lvl;

    int checks = 0;
    int failures = 0;
    int lvl[3];
    int mx[3];

    always #5 clk = ~clk;

    resource_dispenser #(.RECHARGE_PERIOD(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_amount(req_amount),
        .refill(refill),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_grant(rsp_grant), .rsp_kind(rsp_kind),
        .rsp_remaining(rsp_remaining),
        .energy_lvl(energy_lvl), .tracer_lvl(tracer_lvl), .fluid_lvl(fluid_lvl)
    );

    function automatic logic [17:0] exp_levels();
        return {8'(lvl[0]), 6'(lvl[1]), 4'(lvl[2])};
    endfunction

    function automatic void model_fill();
        for (int i = 0; i < 3; i++) lvl[i] = mx[i];
    endfunction

    // Reference: reserved kind, oversize or insufficient amount is denied; otherwise subtract.
    function automatic void model_req(input int k, input int a, output logic g, output int rem);
        if (k == 3) begin
            g = 1'b0; rem = 0;
        end else if (a > mx[k] || a > lvl[k]) begin
            g = 1'b0; rem = lvl[k];
        end else begin
            lvl[k] = lvl[k] - a;
            g = 1'b1; rem = lvl[k];
        end
    endfunction

    // Runs one request from an IDLE negedge to the IDLE negedge after the response handshake.
    task automatic do_txn(input int k, input int a, output int lat, output logic g,
                          output logic [1:0] rk, output logic [7:0] rem);
        req_valid = 1'b1; req_kind = k[1:0]; req_amount = a[7:0]; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        g = rsp_grant; rk = rsp_kind; rem = rsp_remaining;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_fill();
        checks++;
        if ({req_ready, rsp_valid, rsp_grant, rsp_kind, rsp_remaining} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {req_ready, rsp_valid, rsp_grant, rsp_kind, rsp_remaining});
        end
        checks++;
        if ({energy_lvl, tracer_lvl, fluid_lvl} !== exp_levels()) begin
            failures++;
            $display("FAIL reset_levels got=%0h exp=%0h", {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%0b exp=1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic run_checked(input string name, input int k, input int a);
        int lat; logic g; logic [1:0] rk; logic [7:0] rem; logic eg; int erem;
        model_req(k, a, eg, erem);
        do_txn(k, a, lat, g, rk, rem);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL %s_latency got=%0d exp=3", name, lat); end
        checks++;
        if ({g, rk, rem} !== {eg, k[1:0], erem[7:0]}) begin
            failures++;
            $display("FAIL %s_rsp k=%0d a=%0d got g=%0b kind=%0d rem=%0d exp g=%0b kind=%0d rem=%0d",
                     name, k, a, g, rk, rem, eg, k, erem);
        end
        checks++;
        if ({energy_lvl, tracer_lvl, fluid_lvl} !== exp_levels()) begin
            failures++;
            $display("FAIL %s_levels got=%0h exp=%0h", name, {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
    endtask

    task automatic test_directed();
        run_checked("energy100", 0, 100);
        run_checked("fluid16", 2, 16);
        run_checked("tracer63a", 1, 63);
        run_checked("tracer63b", 1, 63);
        run_checked("kind3", 3, 0);
        run_checked("energy0", 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                refill = 1'b1;
                @(negedge clk);
                refill = 1'b0;
                model_fill();
                checks++;
                if ({energy_lvl, tracer_lvl, fluid_lvl} !== exp_levels()) begin
                    failures++;
                    $display("FAIL rand_refill got=%0h exp=%0h", {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
                end
            end else begin
                int k, a;
                k = $urandom_range(0, 3);
                a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 255);
                run_checked("rand", k, a);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic eg; int erem;
        model_req(0, 7, eg, erem);
        req_valid = 1'b1; req_kind = 2'd0; req_amount = 8'd7; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_grant, rsp_kind, rsp_remaining} !== {1'b1, 1'b0, eg, 2'd0, erem[7:0]}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%0b rdy=%0b g=%0b k=%0d rem=%0d exp v=1 rdy=0 g=%0b k=0 rem=%0d",
                         c, rsp_valid, req_ready, rsp_grant, rsp_kind, rsp_remaining, eg, erem);
            end
            refill = (c == 2);
            @(negedge clk);
            refill = 1'b0;
        end
        checks++;
        if ({energy_lvl, tracer_lvl, fluid_lvl} !== exp_levels()) begin
            failures++;
            $display("FAIL bp_refill_ignored got=%0h exp=%0h", {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, energy_lvl, tracer_lvl, fluid_lvl} !== {1'b1, exp_levels()}) begin
            failures++;
            $display("FAIL bp_after got rdy=%0b lv=%0h exp rdy=1 lv=%0h", req_ready,
                     {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1; req_kind = 2'd0; req_amount = 8'd10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL abort_in_reset got=%0b exp=0", {req_ready, rsp_valid});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_fill();
        #1;
        checks++;
        if ({req_ready, energy_lvl, tracer_lvl, fluid_lvl} !== {1'b1, exp_levels()}) begin
            failures++;
            $display("FAIL abort_release got rdy=%0b lv=%0h exp rdy=1 lv=%0h", req_ready,
                     {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
        @(negedge clk);
    endtask

    task automatic test_refill_priority();
        int lat; logic eg; int erem;
        run_checked("drain", 1, 20);
        req_valid = 1'b1; req_kind = 2'd1; req_amount = 8'd5; refill = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL prio_ready got=%0b exp=0", req_ready); end
        @(negedge clk);
        refill = 1'b0;
        model_fill();
        #1;
        checks++;
        if ({req_ready, rsp_valid, energy_lvl, tracer_lvl, fluid_lvl} !== {2'b10, exp_levels()}) begin
            failures++;
            $display("FAIL prio_refilled got rdy=%0b v=%0b lv=%0h exp rdy=1 v=0 lv=%0h", req_ready, rsp_valid,
                     {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
        model_req(1, 5, eg, erem);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
        checks++;
        if ({lat[3:0], rsp_grant, rsp_remaining} !== {4'd3, eg, erem[7:0]}) begin
            failures++;
            $display("FAIL prio_waited_req got lat=%0d g=%0b rem=%0d exp lat=3 g=%0b rem=%0d",
                     lat, rsp_grant, rsp_remaining, eg, erem);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_idle_static();
        run_checked("static_drain", 2, 9);
        repeat (40) @(negedge clk);
        checks++;
        if ({energy_lvl, tracer_lvl, fluid_lvl} !== exp_levels()) begin
            failures++;
            $display("FAIL idle_static got=%0h exp=%0h", {energy_lvl, tracer_lvl, fluid_lvl}, exp_levels());
        end
    endtask

    task automatic test_recharge();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b1; req_kind = 2'd0; req_amount = 8'd5; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_grant, rsp_remaining} !== {2'b11, 8'd250}) begin
            failures++;
            $display("FAIL rc_grant got v=%0b g=%0b rem=%0d exp v=1 g=1 rem=250", rsp_valid, rsp_grant, rsp_remaining);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, energy_lvl} !== {1'b1, 8'd250}) begin
            failures++;
            $display("FAIL rc_first_idle got rdy=%0b e=%0d exp rdy=1 e=250", req_ready, energy_lvl);
        end
        @(negedge clk);
        checks++;
        if (energy_lvl !== 8'd251) begin failures++; $display("FAIL rc_pending_applied got=%0d exp=251", energy_lvl); end
        repeat (3) @(negedge clk);
        checks++;
        if (energy_lvl !== 8'd252) begin failures++; $display("FAIL rc_next_tick got=%0d exp=252", energy_lvl); end
        rsp_ready = 1'b0;
        repeat (24) @(negedge clk);
        checks++;
        if ({energy_lvl, tracer_lvl, fluid_lvl} !== {8'd255, 6'd63, 4'd15}) begin
            failures++;
            $display("FAIL rc_saturate got=%0h exp=%0h", {energy_lvl, tracer_lvl, fluid_lvl}, {8'd255, 6'd63, 4'd15});
        end
    endtask

    initial begin
        mx[0] = 255; mx[1] = 63; mx[2] = 15;
        model_fill();
        test_reset();
`ifdef RESOURCE_DISPENSER_RECHARGE_EN
        test_recharge();
`else
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_refill_priority();
        test_random();
        test_idle_static();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
